// File: rtl/div_pkg.sv
// Shared constants, state encoding and sign helper for the sequential divider.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int ITER_CNT  = 32;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PREP,
    S_RUN,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic [DIV_WIDTH-1:0] abs_val(input logic [DIV_WIDTH-1:0] v,
                                                   input logic en);
    return (en && v[DIV_WIDTH-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: 33-bit trial subtract of the divisor from
// the shifted partial remainder, keeping the difference or restoring.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   i_part,
  input  logic [WIDTH-1:0] i_div,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0] w_diff;

  // i_part < 2*divisor always holds, so bit WIDTH of the wrapped difference is the borrow.
  assign w_diff = i_part - {1'b0, i_div};
  assign o_qbit = ~w_diff[WIDTH];
  assign o_rem  = o_qbit ? w_diff[WIDTH-1:0] : i_part[WIDTH-1:0];

endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle signed/unsigned restoring divider, one quotient bit per cycle.
//   state  | meaning
//   IDLE   | waiting for start; operands latched on start
//   PREP   | divide-by-zero short cut, or operands converted to magnitudes
//   RUN    | 32 shift/subtract iterations, counter 31 down to 0
//   FIX    | sign correction, results written to output registers
//   DONE   | done pulse, results valid
module sequential_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signedOp,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             divByZero
);
  import div_pkg::*;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic             r_sgn;
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_dbz;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_qbit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_PREP;
      S_PREP:  w_next = (r_div == '0) ? S_DONE : S_RUN;
      S_RUN:   if (r_cnt == '0) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // r_quo starts as the dividend and is shifted out MSB-first while quotient bits shift in.
  div_step #(.WIDTH(WIDTH)) u_step (
    .i_part (({r_rem, r_quo[WIDTH-1]})),
    .i_div  (r_div),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_quo       <= '0;
      r_rem       <= '0;
      r_div       <= '0;
      r_sgn       <= 1'b0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_dbz       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_quo <= dividend;
            r_div <= divisor;
            r_sgn <= signedOp;
          end
        end
        S_PREP: begin
          if (r_div == '0) begin
            r_quotient  <= '1;
            r_remainder <= r_quo;
            r_dbz       <= 1'b1;
          end else begin
            r_quo   <= abs_val(r_quo, r_sgn);
            r_div   <= abs_val(r_div, r_sgn);
            r_neg_q <= r_sgn & (r_quo[WIDTH-1] ^ r_div[WIDTH-1]);
            r_neg_r <= r_sgn & r_quo[WIDTH-1];
            r_rem   <= '0;
            r_cnt   <= CNT_W'(ITER_CNT - 1);
          end
        end
        S_RUN: begin
          r_rem <= w_step_rem;
          r_quo <= {r_quo[WIDTH-2:0], w_qbit};
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        S_FIX: begin
          r_quotient  <= r_neg_q ? -r_quo : r_quo;
          r_remainder <= r_neg_r ? -r_rem : r_rem;
          r_dbz       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign divByZero = r_dbz;

endmodule

// File: tb/tb_sequential_divider.sv
// Directed, table-driven bench for sequential_divider plus multi-cycle corner sequences.
module tb_sequential_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        signedOp = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        divByZero;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[13];

  sequential_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .signedOp  (signedOp),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Starts a division and returns in the cycle done is seen (or after the budget expires).
  task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic busy_ok);
    signedOp = s;
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    lat     = -1;
    busy_ok = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (!busy) busy_ok = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    int          lat;
    logic        bok;
    int          n_done;
    int          first;
    logic [31:0] q_first;
    logic [31:0] r_first;
    logic        quiet;

    vecs[0]  = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 35};
    vecs[1]  = '{1'b1, 32'hFFFFFFF9,   32'h2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0, 35};
    vecs[2]  = '{1'b0, 32'hFFFFFFF9,   32'h2,          32'h7FFFFFFC,   32'h1,          1'b0, 35};
    vecs[3]  = '{1'b0, 32'd12345,      32'd0,          32'hFFFFFFFF,   32'd12345,      1'b1, 2};
    vecs[4]  = '{1'b0, 32'd10,         32'd3,          32'd3,          32'd1,          1'b0, 35};
    vecs[5]  = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'h0,          1'b0, 35};
    vecs[6]  = '{1'b1, 32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0, 35};
    vecs[7]  = '{1'b1, 32'hFFFFCFC7,   32'd0,          32'hFFFFFFFF,   32'hFFFFCFC7,   1'b1, 2};
    vecs[8]  = '{1'b0, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0, 35};
    vecs[9]  = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5,          1'b0, 35};
    vecs[10] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 35};
    vecs[11] = '{1'b0, 32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 35};
    vecs[12] = '{1'b0, 32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 35};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_dbz", {31'b0, divByZero}, 32'd0);
    rst_n = 1'b1;

    // First vector starts on the first edge after release; each following one back-to-back.
    for (int i = 0; i < 13; i++) begin
      run_div(vecs[i].sgn, vecs[i].a, vecs[i].b, lat, bok);
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d_busy_span", i), {31'b0, bok}, 32'd1);
      chk($sformatf("v%0d_quotient", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_remainder", i), remainder, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), {31'b0, divByZero}, {31'b0, vecs[i].dbz});
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle_done", i), {30'b0, busy, done}, 32'd0);
      chk($sformatf("v%0d_hold_q", i), quotient, vecs[i].q);
      chk($sformatf("v%0d_hold_r", i), remainder, vecs[i].r);
    end

    // start pulsed with new operands while busy must be ignored
    signedOp = 1'b0;
    dividend = 32'd1000;
    divisor  = 32'd10;
    start    = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    n_done  = 0;
    first   = -1;
    q_first = '0;
    r_first = '0;
    for (int c = 1; c <= 80; c++) begin
      if (c == 4) begin
        start    = 1'b1;
        signedOp = 1'b1;
        dividend = 32'd7;
        divisor  = 32'd7;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        n_done++;
        if (first < 0) begin
          first   = c;
          q_first = quotient;
          r_first = remainder;
        end
      end
      @(posedge clk); #1;
    end
    chk("busy_start_latency", 32'(first), 32'd35);
    chk("busy_start_quotient", q_first, 32'd100);
    chk("busy_start_remainder", r_first, 32'd0);
    chk("busy_start_done_count", 32'(n_done), 32'd1);

    // Reset in the middle of RUN abandons the division
    signedOp = 1'b0;
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    #1;
    chk("midrun_rst_busy", {31'b0, busy}, 32'd0);
    chk("midrun_rst_done", {31'b0, done}, 32'd0);
    chk("midrun_rst_quotient", quotient, 32'd0);
    chk("midrun_rst_remainder", remainder, 32'd0);
    chk("midrun_rst_dbz", {31'b0, divByZero}, 32'd0);
    quiet = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (busy || done) quiet = 1'b0;
    end
    chk("midrun_rst_quiet", {31'b0, quiet}, 32'd1);
    start = 1'b0;
    rst_n = 1'b1;
    run_div(1'b0, 32'd9, 32'd4, lat, bok);
    chk("after_rst_latency", 32'(lat), 32'd35);
    chk("after_rst_quotient", quotient, 32'd2);
    chk("after_rst_remainder", remainder, 32'd1);
    chk("after_rst_dbz", {31'b0, divByZero}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width; only 32 is required to be supported.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port signedOp  input  1  1 = two's-complement division, 0 = unsigned; sampled with start.
REQ-006 SHALL have port dividend  input  32  numerator; sampled with start.
REQ-007 SHALL have port divisor  input  32  denominator; sampled with start.
REQ-008 SHALL have port busy  output  1  high from cycle after accepted start until done cycle inclusive.
REQ-009 SHALL have port done  output  1  one-cycle pulse; results valid in that cycle.
REQ-010 SHALL have port quotient  output  32  result quotient.
REQ-011 SHALL have port remainder  output  32  result remainder.
REQ-012 SHALL have port divByZero  output  1  set with done when divisor was 0; held with results.

Function
REQ-013 SHALL implement FSM states IDLE, PREP, RUN, FIX, DONE.
REQ-014 SHALL, in IDLE with start=1 at edge N, latch operands and signedOp, enter PREP at N+1.
REQ-015 SHALL, in PREP, when divisor=0 go directly to DONE (done at N+2), else convert operands to magnitudes (signedOp=1 only) and enter RUN.
REQ-016 SHALL perform RUN as 32 iterations, one per cycle, 5-bit counter 31 down to 0: shift partial remainder left one, bringing in the next dividend bit MSB-first; 33-bit trial subtract of divisor; no borrow -> keep difference, quotient bit 1; borrow -> restore, bit 0.
REQ-017 SHALL, in FIX, negate quotient when signedOp=1 and operand signs differ, negate remainder when signedOp=1 and dividend negative.
REQ-018 SHALL assert done and update quotient/remainder/divByZero in DONE, then return to IDLE next cycle; non-zero-divisor latency start-edge to done = 35 cycles (done high in cycle N+35).
REQ-019 SHALL hold quotient, remainder, divByZero stable after done until the next done.
REQ-020 SHALL ignore start while busy=1; no restart, no queuing.
REQ-021 SHALL accept a new start in the IDLE cycle directly after DONE (back-to-back throughput one division per 36 cycles).
REQ-022 SHALL produce quotient=0xFFFFFFFF, remainder=dividend, divByZero=1 for divisor=0 regardless of signedOp.
REQ-023 SHALL produce quotient=0x80000000, remainder=0 for signed 0x80000000 / 0xFFFFFFFF (overflow wraps, no flag).
REQ-024 SHALL clear divByZero on any non-zero-divisor completion.
REQ-025 SHALL satisfy dividend = quotient*divisor + remainder (mod 2^32) with |remainder| < |divisor| for all non-zero divisors.

Reset
REQ-026 SHALL, on rst_n low, immediately force state IDLE, counter 0, busy=0, done=0, quotient=0, remainder=0, divByZero=0.
REQ-027 SHALL abandon any in-progress division on reset without producing done; start is ignored while rst_n=0.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL place FSM state encoding typedef and WIDTH/iteration-count constants in shared package div_pkg.
REQ-030 SHALL implement the 33-bit trial subtract/restore as one sub-module div_step (combinational, partial remainder + divisor in, next remainder + quotient bit out); no other sub-modules.

Verification
REQ-031 SHALL cover unsigned 100/7 -> quotient=14, remainder=2, divByZero=0, done exactly at N+35, busy high N+1..N+35.
REQ-032 SHALL cover signed -7/2 (0xFFFFFFF9/0x2) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF; same operands unsigned -> quotient=0x7FFFFFFC, remainder=1.
REQ-033 SHALL cover 12345/0 -> quotient=0xFFFFFFFF, remainder=12345, divByZero=1, done at N+2; following 10/3 clears divByZero.
REQ-034 SHALL cover signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-035 SHALL cover start pulsed at N+5 with new operands during busy -> first result unaffected, no second done.
REQ-036 SHALL cover rst_n low at N+10 mid-RUN -> all outputs 0 immediately, no done; fresh 9/4 after release -> quotient=2, remainder=1.
